wb_rr_arbiter: RTL and testbench
================================

// Module: wb_rr_arbiter
// PURPOSE
//  Two-master round-robin Wishbone arbiter in front of the interconnect's single m0 port.
//  Lets the chronometer master (m0) and a second requester (m1, e.g. a debug/config master)
//  share the bus to the counter and display slaves. Grant is held for a whole cyc burst.
//  Registered grant FSM; master signals are muxed combinationally from the registered grant.
// PARAMETERS
//  WB_DATA_WIDTH   32    data bus width
//  WB_ADDR_WIDTH   11    address bus width
//  GRANULARITY     8     bits per sel lane; sel width = WB_DATA_WIDTH/GRANULARITY
//  TIMEOUT_CYCLES  16    watchdog limit, stb-without-ack cycles (used only with WB_ARB_TIMEOUT_EN)
// PORTS
//  clk_i              in   1     system clock (single clock domain)
//  rst_i              in   1     asynchronous, active-high reset
//  mN_adr_i (N=0,1)   in   WB_ADDR_WIDTH  master N address
//  mN_dat_i           in   WB_DATA_WIDTH  master N write data
//  mN_dat_o           out  WB_DATA_WIDTH  read data to master N (= s_dat_i, broadcast)
//  mN_sel_i           in   SEL_W  master N byte select
//  mN_we_i/cyc_i/stb_i in  1     master N write enable / cycle / strobe
//  mN_ack_o, mN_err_o out  1     ack / error to master N, only when N is granted
//  s_adr_o/dat_o/sel_o out ADDR/DATA/SEL_W  muxed master request toward interconnect
//  s_we_o/cyc_o/stb_o out  1     muxed control toward interconnect
//  s_dat_i            in   WB_DATA_WIDTH  read data from interconnect
//  s_ack_i, s_err_i   in   1     ack / error from interconnect
//  gnt_o              out  2     one-hot grant {m1,m0}; 2'b00 when idle
// BEHAVIOUR
//  - Reset (async, immediate): state IDLE, gnt_o=00, last=1 (m0 wins first tie); all s_* outputs
//    and mN_ack_o/mN_err_o = 0; watchdog count = 0. Reset mid-cycle aborts without ack.
//  - States IDLE, GNT0, GNT1. Arbitration latency 1 clk: request seen in IDLE -> grant next edge.
//  - IDLE: only m0_cyc -> GNT0; only m1_cyc -> GNT1; both -> master != last. Else stay.
//  - GNTn: hold while mN_cyc_i=1 (no preemption). When mN_cyc_i=0: if other cyc=1 go directly to
//    GNT(other) (no idle cycle), else IDLE. On grant entry last<=n.
//  - IDLE: s_cyc_o=s_stb_o=s_we_o=0, s_adr_o=s_dat_o=s_sel_o=0.
//  - GNTn: s_* = mN_* combinationally; mN_ack_o=s_ack_i, mN_err_o=s_err_i; other master ack/err=0.
//  - Grant released while s_ack_i high: that ack goes to the still-granted master only.
//  - mN_dat_o = s_dat_i unconditionally; masters qualify with their own ack.
// CONFIGURATION
//  - WB_ARB_TIMEOUT_EN defined: watchdog counts clks with s_stb_o=1 and s_ack_i=s_err_i=0; cleared
//    on ack/err or grant change. At count == TIMEOUT_CYCLES-1: mN_err_o=1 for exactly 1 clk,
//    s_cyc_o/s_stb_o forced 0 that clk, FSM -> IDLE (master still holding cyc re-arbitrates).
//  - Undefined: no counter logic; a stalled slave holds the grant indefinitely.
// STRUCTURE
//  - Shared package wb_arb_pkg.vh: state encodings (ARB_IDLE/ARB_GNT0/ARB_GNT1), SEL_W derivation,
//    gnt one-hot constants.
//  - One sub-module natural: wb_arb_watchdog (counter + expiry pulse), instantiated only under
//    WB_ARB_TIMEOUT_EN. Mux and FSM stay in wb_rr_arbiter.
// TESTING
//  - m0 single write adr=0x004 dat=0x1234 -> gnt_o=01 one clk later, s_adr_o=0x004, ack to m0 only.
//  - m0,m1 assert cyc same clk after reset -> m0 granted; m0 drops cyc -> GNT1 next edge, no IDLE.
//  - m0 back-to-back bursts while m1 waits -> after first m0 release, m1 granted (fairness).
//  - m1 read, slave returns 0xCAFE with ack -> m1_dat_o=0xCAFE, m1_ack_o=1, m0_ack_o=0.
//  - rst_i pulsed mid m0 cycle -> gnt_o=00, s_cyc_o=0 same clk, no ack delivered.
//  - WB_ARB_TIMEOUT_EN, slave never acks -> m0_err_o=1 on 16th stb cycle, then IDLE.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared state encodings and grant constants for the Wishbone round-robin arbiter
package wb_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_GNT0 = 2'd1,
        ARB_GNT1 = 2'd2
    } arb_state_e;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

endpackage

// File: rtl/wb_arb_watchdog.sv
// rtl/wb_arb_watchdog.sv - stalled-strobe counter; pulses expire_o on the TIMEOUT_CYCLES-th stalled cycle
module wb_arb_watchdog
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic stall_i,
    input  logic clear_i,
    output logic expire_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign expire_o = stall_i && (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        count_d = count_q;
        if (clear_i || expire_o) begin
            count_d = '0;
        end else if (stall_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// rtl/wb_rr_arbiter.sv - two-master round-robin Wishbone arbiter, grant held per cyc burst
// Optional stalled-slave watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int WB_DATA_WIDTH  = 32,
    parameter int WB_ADDR_WIDTH  = 11,
    parameter int GRANULARITY    = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [WB_ADDR_WIDTH-1:0]               m0_adr_i,
    input  logic [WB_DATA_WIDTH-1:0]               m0_dat_i,
    output logic [WB_DATA_WIDTH-1:0]               m0_dat_o,
    input  logic [WB_DATA_WIDTH/GRANULARITY-1:0]   m0_sel_i,
    input  logic                                   m0_we_i,
    input  logic                                   m0_cyc_i,
    input  logic                                   m0_stb_i,
    output logic                                   m0_ack_o,
    output logic                                   m0_err_o,
    input  logic [WB_ADDR_WIDTH-1:0]               m1_adr_i,
    input  logic [WB_DATA_WIDTH-1:0]               m1_dat_i,
    output logic [WB_DATA_WIDTH-1:0]               m1_dat_o,
    input  logic [WB_DATA_WIDTH/GRANULARITY-1:0]   m1_sel_i,
    input  logic                                   m1_we_i,
    input  logic                                   m1_cyc_i,
    input  logic                                   m1_stb_i,
    output logic                                   m1_ack_o,
    output logic                                   m1_err_o,
    output logic [WB_ADDR_WIDTH-1:0]               s_adr_o,
    output logic [WB_DATA_WIDTH-1:0]               s_dat_o,
    output logic [WB_DATA_WIDTH/GRANULARITY-1:0]   s_sel_o,
    output logic                                   s_we_o,
    output logic                                   s_cyc_o,
    output logic                                   s_stb_o,
    input  logic [WB_DATA_WIDTH-1:0]               s_dat_i,
    input  logic                                   s_ack_i,
    input  logic                                   s_err_i,
    output logic [1:0]                             gnt_o
);

    arb_state_e state_q;
    arb_state_e state_d;
    logic       last_q;
    logic       last_d;
    logic       stb_raw;
    logic       wd_expire;

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    // Round-robin: on a tie the master that was not granted last wins (last_q=1 means m1).
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
                    state_d = ARB_GNT0;
                end else if (m1_cyc_i) begin
                    state_d = ARB_GNT1;
                end
            end
            ARB_GNT0: begin
                if (!m0_cyc_i) begin
                    state_d = m1_cyc_i ? ARB_GNT1 : ARB_IDLE;
                end
            end
            ARB_GNT1: begin
                if (!m1_cyc_i) begin
                    state_d = m0_cyc_i ? ARB_GNT0 : ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
        if (wd_expire) begin
            state_d = ARB_IDLE;
        end
        if (state_d == ARB_GNT0 && state_q != ARB_GNT0) begin
            last_d = 1'b0;
        end else if (state_d == ARB_GNT1 && state_q != ARB_GNT1) begin
            last_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ARB_IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        s_we_o   = 1'b0;
        s_cyc_o  = 1'b0;
        stb_raw  = 1'b0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        gnt_o    = GNT_NONE;
        unique case (state_q)
            ARB_GNT0: begin
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                s_we_o   = m0_we_i;
                s_cyc_o  = m0_cyc_i;
                stb_raw  = m0_stb_i;
                m0_ack_o = s_ack_i;
                m0_err_o = s_err_i || wd_expire;
                gnt_o    = GNT_M0;
            end
            ARB_GNT1: begin
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                s_we_o   = m1_we_i;
                s_cyc_o  = m1_cyc_i;
                stb_raw  = m1_stb_i;
                m1_ack_o = s_ack_i;
                m1_err_o = s_err_i || wd_expire;
                gnt_o    = GNT_M1;
            end
            default: ;
        endcase
        // On expiry the bus cycle is withdrawn in the same clock the error is reported.
        if (wd_expire) begin
            s_cyc_o = 1'b0;
        end
    end

    assign s_stb_o = stb_raw && !wd_expire;

`ifdef WB_ARB_TIMEOUT_EN
    wb_arb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .stall_i  (stb_raw && !s_ack_i && !s_err_i),
        .clear_i  (s_ack_i || s_err_i || (state_d != state_q)),
        .expire_o (wd_expire)
    );
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYCLES;
    assign wd_expire      = 1'b0;
`endif

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb/tb_wb_rr_arbiter.sv - self-checking bench for wb_rr_arbiter with directed and randomized scenarios
`timescale 1ns/1ps
module tb_wb_rr_arbiter;

    localparam int DW = 32;
    localparam int AW = 11;
    localparam int SW = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [AW-1:0] m0_adr_i, m1_adr_i, s_adr_o;
    logic [DW-1:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
    logic [SW-1:0] m0_sel_i, m1_sel_i, s_sel_o;
    logic          m0_we_i, m0_cyc_i, m0_stb_i, m0_ack_o, m0_err_o;
    logic          m1_we_i, m1_cyc_i, m1_stb_i, m1_ack_o, m1_err_o;
    logic          s_we_o, s_cyc_o, s_stb_o, s_ack_i, s_err_i;
    logic [1:0]    gnt_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    wb_rr_arbiter #(
        .WB_DATA_WIDTH  (DW),
        .WB_ADDR_WIDTH  (AW),
        .GRANULARITY    (8),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i (clk), .rst_i (rst_i),
        .m0_adr_i (m0_adr_i), .m0_dat_i (m0_dat_i), .m0_dat_o (m0_dat_o), .m0_sel_i (m0_sel_i),
        .m0_we_i (m0_we_i), .m0_cyc_i (m0_cyc_i), .m0_stb_i (m0_stb_i),
        .m0_ack_o (m0_ack_o), .m0_err_o (m0_err_o),
        .m1_adr_i (m1_adr_i), .m1_dat_i (m1_dat_i), .m1_dat_o (m1_dat_o), .m1_sel_i (m1_sel_i),
        .m1_we_i (m1_we_i), .m1_cyc_i (m1_cyc_i), .m1_stb_i (m1_stb_i),
        .m1_ack_o (m1_ack_o), .m1_err_o (m1_err_o),
        .s_adr_o (s_adr_o), .s_dat_o (s_dat_o), .s_sel_o (s_sel_o),
        .s_we_o (s_we_o), .s_cyc_o (s_cyc_o), .s_stb_o (s_stb_o),
        .s_dat_i (s_dat_i), .s_ack_i (s_ack_i), .s_err_i (s_err_i),
        .gnt_o (gnt_o)
    );

    task automatic clear_inputs();
        m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0; m0_we_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0; m1_we_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        s_dat_i = '0; s_ack_i = 0; s_err_i = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_i = 1'b1;
        m0_cyc_i = 1; m0_stb_i = 1; s_ack_i = 1;
        tick(); tick();
        tests++;
        if (gnt_o !== 2'b00) begin fails++; $display("FAIL reset_gnt got=%b exp=00", gnt_o); end
        tests++;
        if ({s_cyc_o, s_stb_o, s_we_o} !== 3'b000 || s_adr_o !== '0) begin
            fails++; $display("FAIL reset_bus got cyc/stb/we=%b%b%b adr=%h exp=0", s_cyc_o, s_stb_o, s_we_o, s_adr_o);
        end
        tests++;
        if ({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o} !== 4'b0000) begin
            fails++; $display("FAIL reset_ack got=%b exp=0000", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o});
        end
        clear_inputs();
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_single_write();
        m0_adr_i = 11'h004; m0_dat_i = 32'h1234; m0_sel_i = 4'hf;
        m0_we_i = 1; m0_cyc_i = 1; m0_stb_i = 1;
        #1;
        tests++;
        if (gnt_o !== 2'b00) begin fails++; $display("FAIL write_latency got=%b exp=00", gnt_o); end
        tick();
        tests++;
        if (gnt_o !== 2'b01) begin fails++; $display("FAIL write_gnt got=%b exp=01", gnt_o); end
        tests++;
        if (s_adr_o !== 11'h004 || s_dat_o !== 32'h1234 || s_we_o !== 1'b1 || s_cyc_o !== 1'b1 || s_sel_o !== 4'hf) begin
            fails++; $display("FAIL write_bus got adr=%h dat=%h we=%b cyc=%b sel=%h exp 004/1234/1/1/f",
                              s_adr_o, s_dat_o, s_we_o, s_cyc_o, s_sel_o);
        end
        s_ack_i = 1;
        #1;
        tests++;
        if (m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0) begin
            fails++; $display("FAIL write_ack got m0=%b m1=%b exp m0=1 m1=0", m0_ack_o, m1_ack_o);
        end
        tick();
        clear_inputs();
        tick();
        tests++;
        if (gnt_o !== 2'b00) begin fails++; $display("FAIL write_release got=%b exp=00", gnt_o); end
    endtask

    task automatic test_tie();
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 11'h3a0;
        tick();
        tests++;
        if (gnt_o !== 2'b01) begin fails++; $display("FAIL tie_first got=%b exp=01", gnt_o); end
        m0_cyc_i = 0; m0_stb_i = 0;
        tick();
        tests++;
        if (gnt_o !== 2'b10 || s_adr_o !== 11'h3a0) begin
            fails++; $display("FAIL tie_handover got gnt=%b adr=%h exp gnt=10 adr=3a0", gnt_o, s_adr_o);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_fairness();
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 11'h011;
        tick();
        tests++;
        if (gnt_o !== 2'b01) begin fails++; $display("FAIL fair_m0_first got=%b exp=01", gnt_o); end
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 11'h022;
        s_ack_i = 1;
        #1;
        tests++;
        if (m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0) begin
            fails++; $display("FAIL fair_ack got m0=%b m1=%b exp m0=1 m1=0", m0_ack_o, m1_ack_o);
        end
        tick();
        s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        tick();
        m0_cyc_i = 1; m0_stb_i = 1;
        #1;
        tests++;
        if (gnt_o !== 2'b10 || s_adr_o !== 11'h022) begin
            fails++; $display("FAIL fair_m1_turn got gnt=%b adr=%h exp gnt=10 adr=022", gnt_o, s_adr_o);
        end
        m1_cyc_i = 0; m1_stb_i = 0;
        tick();
        tests++;
        if (gnt_o !== 2'b01) begin fails++; $display("FAIL fair_back_to_m0 got=%b exp=01", gnt_o); end
        clear_inputs();
        tick();
    endtask

    task automatic test_read();
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 0; m1_adr_i = 11'h010;
        tick();
        s_dat_i = 32'hCAFE; s_ack_i = 1;
        #1;
        tests++;
        if (m1_dat_o !== 32'hCAFE || m0_dat_o !== 32'hCAFE) begin
            fails++; $display("FAIL read_data got m1=%h m0=%h exp=0000cafe", m1_dat_o, m0_dat_o);
        end
        tests++;
        if (m1_ack_o !== 1'b1 || m0_ack_o !== 1'b0 || s_we_o !== 1'b0) begin
            fails++; $display("FAIL read_ack got m1=%b m0=%b we=%b exp 1/0/0", m1_ack_o, m0_ack_o, s_we_o);
        end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        m0_cyc_i = 1; m0_stb_i = 1;
        tick();
        tests++;
        if (gnt_o !== 2'b01) begin fails++; $display("FAIL rstmid_pre got=%b exp=01", gnt_o); end
        #2;
        s_ack_i = 1;
        rst_i = 1;
        #1;
        tests++;
        if (gnt_o !== 2'b00 || s_cyc_o !== 1'b0 || m0_ack_o !== 1'b0) begin
            fails++; $display("FAIL rstmid got gnt=%b cyc=%b ack=%b exp 00/0/0", gnt_o, s_cyc_o, m0_ack_o);
        end
        clear_inputs();
        @(negedge clk);
        rst_i = 0;
        tick();
    endtask

    task automatic test_random();
        int   owner;
        int   last;
        int   run;
        logic own_stb, expire;
        logic [1:0]    exp_gnt;
        logic [AW-1:0] exp_adr;
        logic          exp_cyc;
        logic [3:0]    exp_ae;
        do_reset();
        owner = -1; last = 1; run = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) m0_cyc_i = ~m0_cyc_i;
            if ($urandom_range(0, 3) == 0) m1_cyc_i = ~m1_cyc_i;
            m0_stb_i = m0_cyc_i & 1'($urandom_range(0, 1));
            m1_stb_i = m1_cyc_i & 1'($urandom_range(0, 1));
            m0_adr_i = AW'($urandom); m1_adr_i = AW'($urandom);
            m0_dat_i = $urandom;      m1_dat_i = $urandom;
            m0_we_i  = 1'($urandom);  m1_we_i  = 1'($urandom);
            s_ack_i  = ($urandom_range(0, 2) == 0);
            s_err_i  = !s_ack_i && ($urandom_range(0, 15) == 0);
            s_dat_i  = $urandom;
            #1;
            own_stb = (owner == 0) ? m0_stb_i : (owner == 1) ? m1_stb_i : 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
            expire = own_stb && !s_ack_i && !s_err_i && (run == TO - 1);
`else
            expire = 1'b0;
`endif
            exp_gnt = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
            exp_adr = (owner == 0) ? m0_adr_i : (owner == 1) ? m1_adr_i : '0;
            exp_cyc = ((owner == 0) ? m0_cyc_i : (owner == 1) ? m1_cyc_i : 1'b0) && !expire;
            exp_ae  = {owner == 0 && s_ack_i, owner == 0 && (s_err_i || expire),
                       owner == 1 && s_ack_i, owner == 1 && (s_err_i || expire)};
            tests++;
            if (gnt_o !== exp_gnt || s_adr_o !== exp_adr || s_cyc_o !== exp_cyc) begin
                fails++; $display("FAIL rand_bus[%0d] got gnt=%b adr=%h cyc=%b exp gnt=%b adr=%h cyc=%b",
                                  i, gnt_o, s_adr_o, s_cyc_o, exp_gnt, exp_adr, exp_cyc);
            end
            tests++;
            if ({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o} !== exp_ae) begin
                fails++; $display("FAIL rand_ack[%0d] got=%b exp=%b", i,
                                  {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}, exp_ae);
            end
            @(posedge clk);
            if (expire) begin
                owner = -1; run = 0;
            end else if (owner < 0) begin
                if (m0_cyc_i && m1_cyc_i) owner = 1 - last;
                else if (m0_cyc_i)        owner = 0;
                else if (m1_cyc_i)        owner = 1;
                if (owner >= 0) last = owner;
                run = 0;
            end else if ((owner == 0) ? m0_cyc_i : m1_cyc_i) begin
                if (s_ack_i || s_err_i) run = 0;
                else if (own_stb)       run++;
            end else begin
                if ((owner == 0) ? m1_cyc_i : m0_cyc_i) begin
                    owner = 1 - owner; last = owner;
                end else begin
                    owner = -1;
                end
                run = 0;
            end
            #1;
        end
        clear_inputs();
        tick();
    endtask

`ifdef WB_ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1;
        tick();
        for (int k = 1; k <= TO; k++) begin
            tests++;
            if (k < TO && (m0_err_o !== 1'b0 || s_stb_o !== 1'b1)) begin
                fails++; $display("FAIL timeout_early[%0d] got err=%b stb=%b exp err=0 stb=1", k, m0_err_o, s_stb_o);
            end else if (k == TO && (m0_err_o !== 1'b1 || s_cyc_o !== 1'b0 || s_stb_o !== 1'b0)) begin
                fails++; $display("FAIL timeout_fire got err=%b cyc=%b stb=%b exp 1/0/0", m0_err_o, s_cyc_o, s_stb_o);
            end
            tick();
        end
        tests++;
        if (gnt_o !== 2'b00 || m0_err_o !== 1'b0) begin
            fails++; $display("FAIL timeout_idle got gnt=%b err=%b exp 00/0", gnt_o, m0_err_o);
        end
        tick();
        tests++;
        if (gnt_o !== 2'b01) begin fails++; $display("FAIL timeout_rearb got=%b exp=01", gnt_o); end
        clear_inputs();
        tick();
    endtask
`endif

    initial begin
        clear_inputs();
        rst_i = 1'b1;
        test_reset();
        test_single_write();
        test_tie();
        test_fairness();
        test_read();
        test_reset_mid();
        test_random();
`ifdef WB_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
